// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, the receive-FIFO entry layout and the
// character-timeout length calculation.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef struct packed {
        logic                      ferr;
        logic [UART_DATA_BITS-1:0] data;
    } uart_entry_t;

    // Idle PCLK cycles equal to 'chars' characters of start + data + stop bits.
    function automatic int unsigned to_cyc(input int unsigned chars,
                                           input int unsigned data_bits,
                                           input int unsigned clk_freq,
                                           input int unsigned baud);
        return chars * (data_bits + 2) * (clk_freq / baud);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between UART_RX / APB decode (master) and the receive FIFO (slave).
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 frame_error;
    logic                 rd_en;
    logic                 flush;
    logic                 clr_ovr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_ferr;
    logic                 empty;
    logic                 full;
    logic [LW-1:0]        level;
    logic                 rx_irq;
    logic                 overrun;
    logic                 rx_timeout;

    modport master (
        output rx_data, rx_ready, frame_error, rd_en, flush, clr_ovr,
        input  rd_data, rd_ferr, empty, full, level, rx_irq, overrun, rx_timeout
    );

    modport slave (
        input  rx_data, rx_ready, frame_error, rd_en, flush, clr_ovr,
        output rd_data, rd_ferr, empty, full, level, rx_irq, overrun, rx_timeout
    );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// Entry storage for the receive FIFO: one synchronous write port, one
// asynchronous read port, no reset on the array contents.
module uart_rx_fifo_ram #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DATA_BITS:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [DATA_BITS:0] rdata
);

    logic [DATA_BITS:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between UART_RX and the APB register file: pointers, level, flags.
// Optional character-timeout flag is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int          DATA_BITS     = UART_DATA_BITS,
    parameter int          DEPTH         = 16,
    parameter int          RX_THRESH     = 8,
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned TIMEOUT_CHARS = 4
) (
    input logic           PCLK,
    input logic           PRESETn,
    uart_rx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if ((RX_THRESH < 1) || (RX_THRESH > DEPTH)) begin : g_bad_thresh
        $error("uart_rx_fifo: RX_THRESH must lie in 1..DEPTH");
    end
    if ((BAUD_RATE == 0) || (CLK_FREQ < BAUD_RATE) || (TIMEOUT_CHARS < 1)) begin : g_bad_timing
        $error("uart_rx_fifo: timeout parameters out of range");
    end

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               irq_q, irq_d;
    logic               ovr_q, ovr_d;
    logic               do_push, do_pop, ram_we;
    logic [DATA_BITS:0] head;

    always_comb begin
        do_pop   = bus.rd_en && !empty_q;
        // A full FIFO still accepts a byte when a pop frees the head slot this cycle.
        do_push  = bus.rx_ready && (!full_q || bus.rd_en);
        ram_we   = do_push && !bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovr_d    = ovr_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
        irq_d   = (level_d >= LW'(RX_THRESH));
        if (bus.rx_ready && full_q && !bus.rd_en && !bus.flush) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
        end
    end

    uart_rx_fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk   (PCLK),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({bus.frame_error, bus.rx_data}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Stale array contents are masked so the head reads as zero when empty.
    assign bus.rd_data = empty_q ? '0 : head[DATA_BITS-1:0];
    assign bus.rd_ferr = !empty_q && head[DATA_BITS];
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.level   = level_q;
    assign bus.rx_irq  = irq_q;
    assign bus.overrun = ovr_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TO_CYC = to_cyc(TIMEOUT_CHARS, DATA_BITS, CLK_FREQ, BAUD_RATE);
    localparam int          CW     = $clog2(TO_CYC) + 1;

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        if (bus.rx_ready || do_pop || bus.flush || empty_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != CW'(TO_CYC - 1)) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
        if (do_pop || bus.flush) begin
            to_flag_d = 1'b0;
        end else if (!empty_q && (to_cnt_q == CW'(TO_CYC - 1))) begin
            to_flag_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign bus.rx_timeout = to_flag_q;
`else
    assign bus.rx_timeout = 1'b0;
`endif

endmodule
